// File: rtl/ahb_mtx_pkg.sv
// Shared types and encodings for the AHB matrix decode/arbitration slice.
//   htrans_t    : AHB HTRANS encodings
//   slave_idx_t : slave index (G, T, R, NONE)
//   arb_state_t : arbiter FSM state, with ARB_IDLE / ARB_A / ARB_B constants
//   onehot_to_idx() : one-hot slave select -> slave index
package ahb_mtx_pkg;

  localparam int unsigned HADDR_W  = 32;
  localparam int unsigned HTRANS_W = 2;
  localparam int unsigned NUM_SLV  = 3;
  localparam int unsigned HOLD_W   = 8;

  typedef enum logic [HTRANS_W-1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    SLV_G    = 2'd0,
    SLV_T    = 2'd1,
    SLV_R    = 2'd2,
    SLV_NONE = 2'd3
  } slave_idx_t;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE = 2'd0;
  localparam arb_state_t ARB_A    = 2'd1;
  localparam arb_state_t ARB_B    = 2'd2;

  // Select bit order: [0]=G, [1]=T, [2]=R
  function automatic slave_idx_t onehot_to_idx(input logic [NUM_SLV-1:0] sel);
    slave_idx_t idx;
    idx = SLV_NONE;
    if (sel[0])      idx = SLV_G;
    else if (sel[1]) idx = SLV_T;
    else if (sel[2]) idx = SLV_R;
    return idx;
  endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational AHB address decoder for one master.
// Ports:
//   haddr  : address phase address (only [31:28] is decoded)
//   htrans : transfer type; a select is only raised for NONSEQ/SEQ
//   sel    : one-hot slave select, [0]=G, [1]=T, [2]=R
//   idx    : slave index matching sel (SLV_NONE when sel is zero)
module ahb_addr_decode
  import ahb_mtx_pkg::*;
#(
  parameter logic [31:0] G_BASE = 32'h0000_0000,
  parameter logic [31:0] T_BASE = 32'h1000_0000,
  parameter logic [31:0] R_BASE = 32'h2000_0000
) (
  input  logic [HADDR_W-1:0]  haddr,
  input  logic [HTRANS_W-1:0] htrans,
  output logic [NUM_SLV-1:0]  sel,
  output slave_idx_t          idx
);

  logic [3:0] region;
  logic       unused_bits;

  assign region      = haddr[31:28];
  assign unused_bits = ^{haddr[27:0], htrans[0]};

  // Priority order keeps sel one-hot even if two bases share a region
  always_comb begin
    sel = '0;
    if (htrans[1]) begin
      if (region == G_BASE[31:28])      sel = 3'b001;
      else if (region == T_BASE[31:28]) sel = 3'b010;
      else if (region == R_BASE[31:28]) sel = 3'b100;
    end
  end

  assign idx = onehot_to_idx(sel);

endmodule

// File: rtl/ahb_decode_arb.sv
// Two-master AHB address decode plus round-robin arbitration of a contended slave.
// Optional feature macro: ARB_BURST_HOLD_EN (keeps a SEQ burst on the granted
// slave from being split, bounded by MAX_HOLD).
// Ports:
//   clk, rst_n                   : clock, async active-low reset
//   HADDR_x, HTRANS_x, HREADY_x  : master x address phase and ready (x = A, B)
//   HSEL_{G,T,R}_x               : combinational slave selects per master
//   arbiter_WR                   : registered, 1 = B owns contended slave, 0 = A
module ahb_decode_arb
  import ahb_mtx_pkg::*;
#(
  parameter logic [31:0] G_BASE   = 32'h0000_0000,
  parameter logic [31:0] T_BASE   = 32'h1000_0000,
  parameter logic [31:0] R_BASE   = 32'h2000_0000,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] HADDR_A,
  input  logic [1:0]  HTRANS_A,
  input  logic        HREADY_A,
  input  logic [31:0] HADDR_B,
  input  logic [1:0]  HTRANS_B,
  input  logic        HREADY_B,
  output logic        HSEL_G_A,
  output logic        HSEL_T_A,
  output logic        HSEL_R_A,
  output logic        HSEL_G_B,
  output logic        HSEL_T_B,
  output logic        HSEL_R_B,
  output logic        arbiter_WR
);

  localparam logic LW_A = 1'b0;
  localparam logic LW_B = 1'b1;

  logic [NUM_SLV-1:0] sel_a, sel_b;
  slave_idx_t         idx_a, idx_b;
  logic               contend;

  arb_state_t         state_q, state_d;
  logic               last_q, last_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  slave_idx_t         gnt_slave_q, gnt_slave_d;
  logic               arb_wr_q;

  logic               owner_ready;
  logic               hold_expired;
  logic               burst_hold;

  ahb_addr_decode #(.G_BASE(G_BASE), .T_BASE(T_BASE), .R_BASE(R_BASE)) u_dec_a (
    .haddr  (HADDR_A),
    .htrans (HTRANS_A),
    .sel    (sel_a),
    .idx    (idx_a)
  );

  ahb_addr_decode #(.G_BASE(G_BASE), .T_BASE(T_BASE), .R_BASE(R_BASE)) u_dec_b (
    .haddr  (HADDR_B),
    .htrans (HTRANS_B),
    .sel    (sel_b),
    .idx    (idx_b)
  );

  assign HSEL_G_A = sel_a[0];
  assign HSEL_T_A = sel_a[1];
  assign HSEL_R_A = sel_a[2];
  assign HSEL_G_B = sel_b[0];
  assign HSEL_T_B = sel_b[1];
  assign HSEL_R_B = sel_b[2];

  assign contend      = |(sel_a & sel_b);
  assign owner_ready  = (state_q == ARB_B) ? HREADY_B : HREADY_A;
  assign hold_expired = (hold_q == HOLD_W'(MAX_HOLD - 1));

`ifdef ARB_BURST_HOLD_EN
  // Owner is continuing a burst on the slave it was granted
  always_comb begin
    burst_hold = 1'b0;
    if (state_q == ARB_A)
      burst_hold = (HTRANS_A == HTRANS_SEQ) && (idx_a == gnt_slave_q);
    else if (state_q == ARB_B)
      burst_hold = (HTRANS_B == HTRANS_SEQ) && (idx_b == gnt_slave_q);
  end
`else
  logic unused_idx_b;
  assign unused_idx_b = ^idx_b;
  assign burst_hold   = 1'b0;
`endif

  // Next-state: round-robin per transfer, held while the owner's data phase stalls
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_slave_d = gnt_slave_q;
    hold_d      = hold_q;

    case (state_q)
      ARB_IDLE: begin
        if (contend) begin
          gnt_slave_d = idx_a;
          if (last_q == LW_B) begin
            state_d = ARB_A;
            last_d  = LW_A;
          end else begin
            state_d = ARB_B;
            last_d  = LW_B;
          end
        end
      end
      ARB_A, ARB_B: begin
        if (owner_ready && !(burst_hold && !hold_expired)) begin
          if (contend) begin
            gnt_slave_d = idx_a;
            if (state_q == ARB_A) begin
              state_d = ARB_B;
              last_d  = LW_B;
            end else begin
              state_d = ARB_A;
              last_d  = LW_A;
            end
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // Grant-cycle counter: cleared on any state change, saturating otherwise
    if (state_d != state_q)
      hold_d = '0;
    else if (state_q != ARB_IDLE && hold_q != {HOLD_W{1'b1}})
      hold_d = hold_q + HOLD_W'(1);
  end

  // State register; arbiter_WR registered from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      last_q      <= LW_B;
      hold_q      <= '0;
      gnt_slave_q <= SLV_NONE;
      arb_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      gnt_slave_q <= gnt_slave_d;
      arb_wr_q    <= (state_d == ARB_B);
    end
  end

  assign arbiter_WR = arb_wr_q;

endmodule

// File: doc/ahb_decode_arb.md
AHB_DECODE_ARB -- requirements
Module: ahb_decode_arb

Interface
REQ-001 SHALL have parameter G_BASE, default 32'h0000_0000, base address of slave G region.
REQ-002 SHALL have parameter T_BASE, default 32'h1000_0000, base address of slave T region.
REQ-003 SHALL have parameter R_BASE, default 32'h2000_0000, base address of slave R region.
REQ-004 SHALL have parameter MAX_HOLD, default 16, maximum consecutive grant cycles under contention (range 2..255).
REQ-005 SHALL have port clk, input, 1, clock; all flops rise-edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port HADDR_A, input, 32, master A address phase.
REQ-008 SHALL have port HTRANS_A, input, 2, master A transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-009 SHALL have port HREADY_A, input, 1, master A ready returned by the response mux.
REQ-010 SHALL have ports HADDR_B, HTRANS_B and HREADY_B, input, 32/2/1, identical meaning for master B.
REQ-011 SHALL have ports HSEL_G_A, HSEL_T_A and HSEL_R_A, output, 1 each, master A slave selects.
REQ-012 SHALL have ports HSEL_G_B, HSEL_T_B and HSEL_R_B, output, 1 each, master B slave selects.
REQ-013 SHALL have port arbiter_WR, output, 1, 1 = master B owns the contended slave, 0 = master A owns it; registered.

Function
REQ-014 SHALL decode combinationally: region = HADDR[31:28]; G if it equals G_BASE[31:28], T if it equals T_BASE[31:28], R if it equals R_BASE[31:28], else no select.
REQ-015 SHALL assert an HSEL only when the decode hits and HTRANS[1]=1; at most one HSEL per master is high.
REQ-016 SHALL flag contention when both masters assert HSEL to the same slave in the same cycle.
REQ-017 SHALL implement FSM states ARB_IDLE, ARB_A and ARB_B; arbiter_WR=1 only in ARB_B.
REQ-018 SHALL, in ARB_IDLE with contention, move to the state of the master that is not last_winner, then update last_winner.
REQ-019 SHALL, in ARB_IDLE without contention, remain in ARB_IDLE; both masters proceed independently.
REQ-020 SHALL, in ARB_A or ARB_B, hold while the owner's HREADY=0, since a data phase is pending.
REQ-021 SHALL, when the owner's HREADY=1 and contention persists, switch to the other master's state: round-robin with one-transfer granularity.
REQ-022 SHALL, when the owner's HREADY=1 and there is no contention, return to ARB_IDLE.
REQ-023 SHALL count hold_cnt (8-bit, saturating) cycles in ARB_A or ARB_B and clear it on every state change.
REQ-024 SHALL force a switch to the other master's state when hold_cnt reaches MAX_HOLD-1 and the owner's HREADY=1, overriding any burst hold.
REQ-025 SHALL resolve simultaneous HREADY=1 release and new contention by REQ-021; the losing master is stalled by the mux via HREADY=0.

Reset
REQ-026 SHALL, on rst_n=0, set state ARB_IDLE, arbiter_WR=0, hold_cnt=0 and last_winner=B, so that A wins the first tie.
REQ-027 SHALL abort a grant on reset mid-transfer, without completion tracking; HSEL outputs follow inputs even while in reset.

Configuration
REQ-028 SHALL, with ARB_BURST_HOLD_EN defined, additionally hold the grant while the owner's HTRANS=SEQ to the same slave, so bursts are not split, until REQ-024 forces a switch.
REQ-029 SHALL, without ARB_BURST_HOLD_EN, arbitrate per transfer as in REQ-020 to REQ-022 only.

Structure
REQ-030 SHALL take htrans_t, slave_idx_t (G, T, R, NONE), arb_state_t and the HTRANS encodings from the shared package ahb_mtx_pkg.
REQ-031 SHALL instantiate sub-module ahb_addr_decode twice (A and B), each mapping HADDR/HTRANS to a one-hot select.

Verification
REQ-032 SHALL cover: A NONSEQ 0x1000_0040, B IDLE -> HSEL_T_A=1, all B selects 0, arbiter_WR stays 0.
REQ-033 SHALL cover: after reset, A and B both NONSEQ to 0x0000_0010 -> next cycle state ARB_A, arbiter_WR=0; after A's HREADY=1 with contention held -> arbiter_WR=1.
REQ-034 SHALL cover: B owns T with HREADY_B=0 for 3 cycles while A requests T -> arbiter_WR held at 1 for all 3 cycles, switching only after HREADY_B=1.
REQ-035 SHALL cover: with ARB_BURST_HOLD_EN defined, MAX_HOLD=4, and A running an 8-beat SEQ burst to R while B contends -> arbiter_WR goes to 1 after 4 grant cycles.
REQ-036 SHALL cover: address 0x5000_0000 on A -> no HSEL asserted for A.
REQ-037 SHALL cover: rst_n asserted in ARB_B -> arbiter_WR=0 immediately (asynchronously), state ARB_IDLE, and the next tie is won by A.
